// File: rtl/idu_issue_buf_pkg.sv
// Shared RV32I pre-decode types: opcode classes, major opcodes, immediate formats.
package idu_issue_buf_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned OPCLS_W = 4;

  typedef enum logic [OPCLS_W-1:0] {
    OPCLS_LUI      = 4'd0,
    OPCLS_AUIPC    = 4'd1,
    OPCLS_JAL      = 4'd2,
    OPCLS_JALR     = 4'd3,
    OPCLS_BRANCH   = 4'd4,
    OPCLS_LOAD     = 4'd5,
    OPCLS_STORE    = 4'd6,
    OPCLS_OP_IMM   = 4'd7,
    OPCLS_OP       = 4'd8,
    OPCLS_MISC_MEM = 4'd9,
    OPCLS_SYSTEM   = 4'd10,
    OPCLS_ILLEGAL  = 4'd11
  } opcls_e;

  // Major opcode field ir[6:2]
  localparam logic [4:0] MAJ_LUI      = 5'b01101;
  localparam logic [4:0] MAJ_AUIPC    = 5'b00101;
  localparam logic [4:0] MAJ_JAL      = 5'b11011;
  localparam logic [4:0] MAJ_JALR     = 5'b11001;
  localparam logic [4:0] MAJ_BRANCH   = 5'b11000;
  localparam logic [4:0] MAJ_LOAD     = 5'b00000;
  localparam logic [4:0] MAJ_STORE    = 5'b01000;
  localparam logic [4:0] MAJ_OP_IMM   = 5'b00100;
  localparam logic [4:0] MAJ_OP       = 5'b01100;
  localparam logic [4:0] MAJ_MISC_MEM = 5'b00011;
  localparam logic [4:0] MAJ_SYSTEM   = 5'b11100;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_NONE = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    opcls_e            opcls;
    logic [RD_W-1:0]   rd;
    logic [XLEN-1:0]   imm;
    logic              illegal;
  } dec_t;

  // Assemble the sign/format-extended immediate for a given format
  function automatic logic [XLEN-1:0] imm_ext(input imm_fmt_e fmt, input logic [31:0] ir);
    logic [XLEN-1:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{ir[31]}}, ir[31:20]};
      FMT_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      FMT_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      FMT_U:   imm = {ir[31:12], 12'b0};
      FMT_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv32i_pre_dec.sv
// Combinational RV32I pre-decoder: opcode class, rd, immediate, illegal flag.
module rv32i_pre_dec
  import idu_issue_buf_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec_c
);

  opcls_e   opcls;
  imm_fmt_e fmt;
  logic     illegal;

  // Classify the major opcode and pick the immediate format
  always_comb begin
    opcls   = OPCLS_ILLEGAL;
    fmt     = FMT_NONE;
    illegal = 1'b1;
    if (ir[1:0] == 2'b11) begin
      illegal = 1'b0;
      case (ir[6:2])
        MAJ_LUI:      begin opcls = OPCLS_LUI;      fmt = FMT_U;    end
        MAJ_AUIPC:    begin opcls = OPCLS_AUIPC;    fmt = FMT_U;    end
        MAJ_JAL:      begin opcls = OPCLS_JAL;      fmt = FMT_J;    end
        MAJ_JALR:     begin opcls = OPCLS_JALR;     fmt = FMT_I;    end
        MAJ_BRANCH:   begin opcls = OPCLS_BRANCH;   fmt = FMT_B;    end
        MAJ_LOAD:     begin opcls = OPCLS_LOAD;     fmt = FMT_I;    end
        MAJ_STORE:    begin opcls = OPCLS_STORE;    fmt = FMT_S;    end
        MAJ_OP_IMM:   begin opcls = OPCLS_OP_IMM;   fmt = FMT_I;    end
        MAJ_OP:       begin opcls = OPCLS_OP;       fmt = FMT_NONE; end
        MAJ_MISC_MEM: begin opcls = OPCLS_MISC_MEM; fmt = FMT_NONE; end
        MAJ_SYSTEM:   begin opcls = OPCLS_SYSTEM;   fmt = FMT_I;    end
        default: begin
          opcls   = OPCLS_ILLEGAL;
          fmt     = FMT_NONE;
          illegal = 1'b1;
        end
      endcase
    end
  end

  assign dec_c = {opcls, ir[11:7], imm_ext(fmt, ir), illegal};

endmodule

// File: rtl/idu_issue_buf.sv
// Issue buffer between IFU and EXU: pre-decodes fetched instructions and queues them.
module idu_issue_buf
  import idu_issue_buf_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ifetch_rsp_vld,
  output logic            ifetch_rsp_rdy,
  input  logic [PC_W-1:0] ifetch_rsp_pc,
  input  logic [31:0]     ifetch_rsp_ir,
  output logic            iexec_req_vld,
  input  logic            iexec_req_rdy,
  output logic [PC_W-1:0] iexec_req_pc,
  output logic [31:0]     iexec_req_ir,
  output logic [3:0]      iexec_req_opcls,
  output logic [4:0]      iexec_req_rd,
  output logic [31:0]     iexec_req_imm,
  output logic            iexec_req_illegal
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  pc_q  [DEPTH];
  logic [31:0]      ir_q  [DEPTH];
  dec_t             dec_q [DEPTH];

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, rdy_q;
  logic             push, pop;
  dec_t             dec_c;

  rv32i_pre_dec u_pre_dec (
    .ir    (ifetch_rsp_ir),
    .dec_c (dec_c)
  );

  assign push = ifetch_rsp_vld & rdy_q & ~flush;
  assign pop  = vld_q & iexec_req_rdy;

  // Next pointer/count; flush wins over any same-cycle push or pop
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = PTR_W'(wr_q + 1'b1);
      if (pop)  rd_d = PTR_W'(rd_q + 1'b1);
      case ({push, pop})
        2'b10:   cnt_d = CNT_W'(cnt_q + 1'b1);
        2'b01:   cnt_d = CNT_W'(cnt_q - 1'b1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer, occupancy and handshake flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= (cnt_d != '0);
      rdy_q <= (cnt_d != CNT_W'(DEPTH));
    end
  end

  // Entry storage; written only on an accepted push, never cleared by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        ir_q[i]  <= '0;
        dec_q[i] <= '0;
      end
    end else if (push) begin
      pc_q[wr_q]  <= ifetch_rsp_pc;
      ir_q[wr_q]  <= ifetch_rsp_ir;
      dec_q[wr_q] <= dec_c;
    end
  end

  assign ifetch_rsp_rdy    = rdy_q;
  assign iexec_req_vld     = vld_q;
  assign iexec_req_pc      = pc_q[rd_q];
  assign iexec_req_ir      = ir_q[rd_q];
  assign iexec_req_opcls   = dec_q[rd_q].opcls;
  assign iexec_req_rd      = dec_q[rd_q].rd;
  assign iexec_req_imm     = dec_q[rd_q].imm;
  assign iexec_req_illegal = dec_q[rd_q].illegal;

endmodule
